multi_try_code_lock: RTL and testbench
======================================

// Module: multi_try_code_lock
// PURPOSE
//  Parametrised combination-lock controller, successor to the fixed 4-step lock.
//  Accepts switch-press sequences of configurable length against a code programmable while unlocked.
//  Tolerates MAX_TRIES wrong entries before a sticky alarm; abandons stalled entries; auto-relocks.
//  Sits between the debounced switch bank and the lock actuator/alarm outputs.
// PARAMETERS
//  N_SW           8     number of switches; one code digit = switch index, DW = $clog2(N_SW)
//  CODE_LEN       4     digits per code, >= 2; IW = $clog2(CODE_LEN)
//  MAX_TRIES      3     wrong entries allowed before ALARM, >= 1; FW = $clog2(MAX_TRIES+1)
//  UNLOCK_CYCLES  1000  cycles UNLOCKED lasts before auto-relock, >= 2
//  ENTRY_CYCLES   5000  idle cycles mid-entry before the partial entry is abandoned
// PORTS
//  clock       in   1         rising-edge clock
//  reset_n     in   1         synchronous active-low reset
//  switches    in   N_SW      debounced switch levels
//  relock      in   1         force LOCKED from UNLOCKED
//  prog_we     in   1         code-digit write strobe, honoured only in UNLOCKED
//  prog_idx    in   IW        digit position to write
//  prog_digit  in   DW        switch index to store
//  locked      out  1         1 = locked (all states except UNLOCKED)
//  alarm       out  1         1 = ALARM state (active high)
//  entry_idx   out  IW        digits correctly entered so far
//  fail_cnt    out  FW        wrong entries since last unlock/reset
// BEHAVIOUR
//  Reset (reset_n=0 at posedge): state LOCKED, entry_idx=0, fail_cnt=0, timers=0, locked=1,
//   alarm=0, code[i]=i (i mod N_SW), prev_sw<=switches (no spurious press on release).
//  All outputs registered. Press detect: rise = switches & ~prev_sw; prev_sw<=switches every cycle.
//  Valid press: exactly one bit of rise set, index d. Two or more rising bits in one cycle = wrong press.
//  Press registered at posedge k updates state/outputs at posedge k (visible after that edge).
//  LOCKED:
//   - valid press, d==code[entry_idx], entry_idx<CODE_LEN-1 -> entry_idx+1, entry timer cleared.
//   - valid press, d==code[CODE_LEN-1] on last digit -> UNLOCKED, entry_idx=0, fail_cnt=0.
//   - wrong/multi press -> entry_idx=0, fail_cnt+1; if new fail_cnt==MAX_TRIES -> ALARM.
//   - no press and entry_idx!=0: entry timer counts; reaching ENTRY_CYCLES -> entry_idx=0,
//     fail_cnt unchanged. Press in same cycle as expiry wins; timer cleared.
//   - entry_idx==0: entry timer held at 0.
//  UNLOCKED: locked=0; unlock timer counts 0..UNLOCK_CYCLES-1, then LOCKED on next edge.
//   - switches ignored (prev_sw still tracks).
//   - prog_we: code[prog_idx]<=prog_digit, unlock timer restarts at 0.
//     prog_idx>=CODE_LEN or prog_digit>=N_SW: write dropped, timer still restarts.
//   - relock -> LOCKED next edge, has priority over prog_we (write dropped) and timeout.
//  ALARM: alarm=1, locked=1, sticky; only reset_n exits. Presses, relock, prog_we ignored.
//  prog_we outside UNLOCKED ignored. Code survives relock; only reset restores the default.
//  Reset mid-entry/mid-unlock/in ALARM: full return to reset values on that edge.
//  fail_cnt saturates at MAX_TRIES; timers never wrap (clear at terminal count).
// TESTING  (N_SW=8, CODE_LEN=4, MAX_TRIES=3, UNLOCK_CYCLES=20, ENTRY_CYCLES=10)
//  1. Reset, press sw0,sw1,sw2,sw3 singly -> entry_idx 1,2,3; locked=0 on 4th press edge;
//     locked=1 exactly 20 cycles later.
//  2. Press sw0, then sw5 -> entry_idx=0, fail_cnt=1; repeat twice -> fail_cnt=3, alarm=1;
//     correct code then ignored; reset_n=0 -> alarm=0.
//  3. Unlock, prog_we idx0..3 = 7,6,5,4 -> unlock timer restarts per write; relock -> locked=1;
//     0,1,2,3 fails (fail_cnt=1), 7,6,5,4 unlocks with fail_cnt=0.
//  4. Press sw0,sw1, idle 10 cycles -> entry_idx=0, fail_cnt=0; press on 10th idle cycle -> timeout suppressed.
//  5. Rise sw0 and sw4 in same cycle -> fail_cnt=1; hold sw2 high through reset release -> no press.
//  6. In UNLOCKED, relock+prog_we same cycle -> locked=1, code unchanged; reset_n=0 mid-entry -> entry_idx=0.

Source files
------------

// File: rtl/multi_try_code_lock.sv
// multi_try_code_lock
//   Combination-lock controller between a debounced switch bank and the lock
//   actuator / alarm. A code of CODE_LEN digits is entered one switch press
//   at a time. A digit is the index of the switch that was pressed. The code
//   can be reprogrammed while the lock is open. After MAX_TRIES wrong entries
//   the lock enters a sticky alarm state that only reset_n clears. An entry
//   that stalls for ENTRY_CYCLES cycles is abandoned. An open lock relocks by
//   itself after UNLOCK_CYCLES cycles.
// Ports
//   clock       rising-edge clock
//   reset_n     synchronous active-low reset
//   switches    debounced switch levels (N_SW)
//   relock      force LOCKED from UNLOCKED
//   prog_we     code-digit write strobe (UNLOCKED only)
//   prog_idx    digit position to write (IW)
//   prog_digit  switch index to store (DW)
//   locked      1 in every state except UNLOCKED
//   alarm       1 in ALARM
//   entry_idx   digits correctly entered so far (IW)
//   fail_cnt    wrong entries since last unlock/reset, saturating (FW)
module multi_try_code_lock #(
  parameter int N_SW          = 8,
  parameter int CODE_LEN      = 4,
  parameter int MAX_TRIES     = 3,
  parameter int UNLOCK_CYCLES = 1000,
  parameter int ENTRY_CYCLES  = 5000,
  localparam int DW = $clog2(N_SW),
  localparam int IW = $clog2(CODE_LEN),
  localparam int FW = $clog2(MAX_TRIES + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [N_SW-1:0] switches,
  input  logic          relock,
  input  logic          prog_we,
  input  logic [IW-1:0] prog_idx,
  input  logic [DW-1:0] prog_digit,
  output logic          locked,
  output logic          alarm,
  output logic [IW-1:0] entry_idx,
  output logic [FW-1:0] fail_cnt
);

  localparam int UW = ($clog2(UNLOCK_CYCLES) < 1) ? 1 : $clog2(UNLOCK_CYCLES);
  localparam int EW = ($clog2(ENTRY_CYCLES) < 1) ? 1 : $clog2(ENTRY_CYCLES);

  localparam logic [UW-1:0] UNLOCK_LAST = UW'(UNLOCK_CYCLES - 1);
  localparam logic [EW-1:0] ENTRY_LAST  = EW'(ENTRY_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX    = IW'(CODE_LEN - 1);
  localparam logic [FW-1:0] FAIL_MAX    = FW'(MAX_TRIES);

  typedef enum logic [1:0] {
    S_LOCKED   = 2'd0,
    S_UNLOCKED = 2'd1,
    S_ALARM    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N_SW-1:0] prev_sw_q;
  logic [IW-1:0]   entry_q, entry_d;
  logic [FW-1:0]   fail_q, fail_d;
  logic [EW-1:0]   etmr_q, etmr_d;
  logic [UW-1:0]   utmr_q, utmr_d;
  logic [DW-1:0]   code_q [CODE_LEN];
  logic [DW-1:0]   code_d [CODE_LEN];
  logic            locked_q, locked_d;
  logic            alarm_q, alarm_d;

  logic [N_SW-1:0] rise;
  logic            press_any;
  logic            press_one;
  logic [DW-1:0]   press_idx;
  logic            prog_ok;

  // Press detection: any rising edge is a press; only a single rising bit
  // is a usable digit, several at once count as a wrong press.
  always_comb begin
    rise      = switches & ~prev_sw_q;
    press_any = |rise;
    press_one = press_any && ((rise & (rise - 1'b1)) == '0);
    press_idx = '0;
    for (int i = 0; i < N_SW; i++) begin
      if (rise[i]) press_idx = DW'(i);
    end
    prog_ok = (int'(prog_idx) < CODE_LEN) && (int'(prog_digit) < N_SW);
  end

  always_comb begin
    state_d = state_q;
    entry_d = entry_q;
    fail_d  = fail_q;
    etmr_d  = etmr_q;
    utmr_d  = utmr_q;
    code_d  = code_q;

    case (state_q)
      S_LOCKED: begin
        utmr_d = '0;
        if (press_any) begin
          // A press always beats a coincident entry timeout.
          etmr_d = '0;
          if (press_one && (press_idx == code_q[entry_q])) begin
            if (entry_q == LAST_IDX) begin
              state_d = S_UNLOCKED;
              entry_d = '0;
              fail_d  = '0;
            end else begin
              entry_d = entry_q + 1'b1;
            end
          end else begin
            entry_d = '0;
            if (fail_q >= FAIL_MAX - 1'b1) begin
              fail_d  = FAIL_MAX;
              state_d = S_ALARM;
            end else begin
              fail_d = fail_q + 1'b1;
            end
          end
        end else if (entry_q != '0) begin
          if (etmr_q == ENTRY_LAST) begin
            entry_d = '0;
            etmr_d  = '0;
          end else begin
            etmr_d = etmr_q + 1'b1;
          end
        end else begin
          etmr_d = '0;
        end
      end

      S_UNLOCKED: begin
        entry_d = '0;
        etmr_d  = '0;
        if (relock) begin
          state_d = S_LOCKED;
          utmr_d  = '0;
        end else if (prog_we) begin
          // Any write attempt, even an out-of-range one, restarts the timer.
          utmr_d = '0;
          if (prog_ok) code_d[prog_idx] = prog_digit;
        end else if (utmr_q == UNLOCK_LAST) begin
          state_d = S_LOCKED;
          utmr_d  = '0;
        end else begin
          utmr_d = utmr_q + 1'b1;
        end
      end

      default: begin
        // ALARM is sticky; everything is held until reset.
        state_d = S_ALARM;
      end
    endcase

    locked_d = (state_d != S_UNLOCKED);
    alarm_d  = (state_d == S_ALARM);
  end

  // State register
  always_ff @(posedge clock) begin
    prev_sw_q <= switches;
    if (!reset_n) begin
      state_q  <= S_LOCKED;
      entry_q  <= '0;
      fail_q   <= '0;
      etmr_q   <= '0;
      utmr_q   <= '0;
      locked_q <= 1'b1;
      alarm_q  <= 1'b0;
      for (int i = 0; i < CODE_LEN; i++) begin
        code_q[i] <= DW'(i % N_SW);
      end
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      fail_q   <= fail_d;
      etmr_q   <= etmr_d;
      utmr_q   <= utmr_d;
      locked_q <= locked_d;
      alarm_q  <= alarm_d;
      code_q   <= code_d;
    end
  end

  assign locked    = locked_q;
  assign alarm     = alarm_q;
  assign entry_idx = entry_q;
  assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_multi_try_code_lock.sv
// tb_multi_try_code_lock
//   Directed bench for multi_try_code_lock (N_SW=8, CODE_LEN=4, MAX_TRIES=3,
//   UNLOCK_CYCLES=20, ENTRY_CYCLES=10). A behavioural model tracks the lock
//   from its rules and is compared with the DUT on every falling edge;
//   literal expectations at key points pin the model.
module tb_multi_try_code_lock;

  localparam int UNLOCK_CYCLES = 20;
  localparam int ENTRY_CYCLES  = 10;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] switches = '0;
  logic       relock = 1'b0;
  logic       prog_we = 1'b0;
  logic [1:0] prog_idx = '0;
  logic [2:0] prog_digit = '0;
  logic       locked;
  logic       alarm;
  logic [1:0] entry_idx;
  logic [1:0] fail_cnt;

  int n_vec = 0;
  int n_bad = 0;

  multi_try_code_lock #(
    .N_SW(8), .CODE_LEN(4), .MAX_TRIES(3),
    .UNLOCK_CYCLES(UNLOCK_CYCLES), .ENTRY_CYCLES(ENTRY_CYCLES)
  ) dut (
    .clock(clock), .reset_n(reset_n), .switches(switches), .relock(relock),
    .prog_we(prog_we), .prog_idx(prog_idx), .prog_digit(prog_digit),
    .locked(locked), .alarm(alarm), .entry_idx(entry_idx), .fail_cnt(fail_cnt)
  );

  always #5 clock = ~clock;

  // Behavioural model: open/alarm flags, digits matched, wrong count,
  // idle cycles mid-entry and age of the open period.
  bit         m_valid = 0;
  bit         m_open = 0;
  bit         m_alm = 0;
  int         m_entry = 0;
  int         m_fail = 0;
  int         m_idle = 0;
  int         m_age = 0;
  int         m_code [4] = '{0, 1, 2, 3};
  logic [7:0] m_prev = '0;

  always @(posedge clock) begin
    logic [7:0] r;
    int nr;
    r = switches & ~m_prev;
    m_prev = switches;
    nr = $countones(r);
    if (!reset_n) begin
      m_valid = 1; m_open = 0; m_alm = 0; m_entry = 0; m_fail = 0;
      m_idle = 0; m_age = 0;
      for (int i = 0; i < 4; i++) m_code[i] = i % 8;
    end else if (m_alm) begin
      // nothing changes until reset
    end else if (m_open) begin
      if (relock) m_open = 0;
      else if (prog_we) begin
        m_age = 0;
        if (int'(prog_idx) < 4 && int'(prog_digit) < 8) m_code[prog_idx] = int'(prog_digit);
      end else begin
        m_age++;
        if (m_age == UNLOCK_CYCLES) m_open = 0;
      end
    end else if (nr > 0) begin
      m_idle = 0;
      if (nr == 1 && r[m_code[m_entry]]) begin
        if (m_entry == 3) begin
          m_open = 1; m_entry = 0; m_fail = 0; m_age = 0;
        end else m_entry++;
      end else begin
        m_entry = 0;
        m_fail++;
        if (m_fail >= 3) begin m_fail = 3; m_alm = 1; end
      end
    end else if (m_entry != 0) begin
      m_idle++;
      if (m_idle == ENTRY_CYCLES) begin m_entry = 0; m_idle = 0; end
    end else m_idle = 0;
  end

  always @(negedge clock) begin
    if (m_valid) begin
      n_vec++;
      if (locked !== !m_open || alarm !== m_alm ||
          entry_idx !== 2'(m_entry) || fail_cnt !== 2'(m_fail)) begin
        n_bad++;
        $display("FAIL model t=%0t locked/alarm/entry/fail got %b/%b/%0d/%0d want %b/%b/%0d/%0d",
                 $time, locked, alarm, entry_idx, fail_cnt, !m_open, m_alm, m_entry, m_fail);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Raise one switch for one edge; it is released before the next edge.
  task automatic press(input int k);
    switches = 8'(1 << k);
    tick(1);
    switches = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  task automatic enter_default();
    for (int i = 0; i < 4; i++) press(i);
  endtask

  initial begin
    // 1: reset values, correct entry, auto-relock after 20 cycles
    tick(1);
    do_reset();
    check("rst_locked", int'(locked), 1);
    check("rst_alarm", int'(alarm), 0);
    check("rst_entry", int'(entry_idx), 0);
    check("rst_fail", int'(fail_cnt), 0);
    press(0); check("t1_entry1", int'(entry_idx), 1);
    press(1); check("t1_entry2", int'(entry_idx), 2);
    press(2); check("t1_entry3", int'(entry_idx), 3);
    press(3); check("t1_unlocked", int'(locked), 0);
    tick(UNLOCK_CYCLES - 1); check("t1_still_open", int'(locked), 0);
    tick(1); check("t1_relocked", int'(locked), 1);

    // 2: three wrong entries -> alarm, sticky until reset
    press(0); press(5);
    check("t2_entry0", int'(entry_idx), 0);
    check("t2_fail1", int'(fail_cnt), 1);
    press(0); press(5);
    press(0); press(5);
    check("t2_fail3", int'(fail_cnt), 3);
    check("t2_alarm", int'(alarm), 1);
    enter_default();
    check("t2_alarm_sticky", int'(alarm), 1);
    check("t2_alarm_locked", int'(locked), 1);
    relock = 1'b1; tick(1); relock = 1'b0;
    reset_n = 1'b0; tick(1);
    check("t2_rst_alarm", int'(alarm), 0);
    check("t2_rst_fail", int'(fail_cnt), 0);
    reset_n = 1'b1; tick(1);

    // 3: program 7,6,5,4; each write restarts the unlock timer
    enter_default();
    check("t3_open", int'(locked), 0);
    for (int i = 0; i < 4; i++) begin
      prog_we = 1'b1; prog_idx = 2'(i); prog_digit = 3'(7 - i);
      tick(1);
    end
    prog_we = 1'b0;
    press(2);
    tick(UNLOCK_CYCLES - 2); check("t3_restart_open", int'(locked), 0);
    relock = 1'b1; tick(1); relock = 1'b0;
    check("t3_relock", int'(locked), 1);
    press(0); check("t3_old_code_fail", int'(fail_cnt), 1);
    for (int i = 0; i < 4; i++) press(7 - i);
    check("t3_new_code_open", int'(locked), 0);
    check("t3_fail_cleared", int'(fail_cnt), 0);
    do_reset();

    // 4: entry timeout, and a press on the expiry cycle wins
    press(0); press(1);
    tick(ENTRY_CYCLES - 1); check("t4_before_timeout", int'(entry_idx), 2);
    tick(1); check("t4_timeout", int'(entry_idx), 0);
    check("t4_timeout_fail", int'(fail_cnt), 0);
    press(0); press(1);
    tick(ENTRY_CYCLES - 1);
    press(2); check("t4_press_wins", int'(entry_idx), 3);
    press(3); check("t4_open", int'(locked), 0);
    do_reset();

    // 5: two rising bits at once, and a held switch across reset release
    switches = 8'b0001_0001; tick(1); switches = '0;
    check("t5_multi_fail", int'(fail_cnt), 1);
    check("t5_multi_entry", int'(entry_idx), 0);
    switches = 8'b0000_0100;
    reset_n = 1'b0; tick(2); reset_n = 1'b1; tick(2);
    check("t5_held_entry", int'(entry_idx), 0);
    check("t5_held_fail", int'(fail_cnt), 0);
    switches = '0; tick(1);
    press(0); check("t5_after_release", int'(entry_idx), 1);
    do_reset();

    // 6: relock beats prog_we; reset mid-entry
    enter_default();
    relock = 1'b1; prog_we = 1'b1; prog_idx = 2'd0; prog_digit = 3'd7;
    tick(1);
    relock = 1'b0; prog_we = 1'b0;
    check("t6_relock_prio", int'(locked), 1);
    enter_default();
    check("t6_code_kept", int'(locked), 0);
    relock = 1'b1; tick(1); relock = 1'b0;
    press(0); press(1);
    check("t6_mid_entry", int'(entry_idx), 2);
    reset_n = 1'b0; tick(1);
    check("t6_rst_entry", int'(entry_idx), 0);
    reset_n = 1'b1; tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
